// File: rtl/mul_pkg.sv
// Shared types and defaults for the Booth multiplier front-end controller.
package mul_pkg;

    localparam int WIDTH_DEF           = 32;
    localparam int TAG_W_DEF           = 4;
    localparam int DONE_TO_PRODUCT_DEF = 1;
    localparam int TIMEOUT_DEF         = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        BUSY    = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } ctrl_state_t;

    function automatic int timer_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Request, datapath and response signals of the multiplier issue controller.
interface mul_issue_ctrl_if
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) ();

    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [WIDTH-1:0]     req_a_i;
    logic [WIDTH-1:0]     req_b_i;
    logic [TAG_W-1:0]     req_tag_i;

    logic                 mul_start_o;
    logic [WIDTH-1:0]     mul_a_o;
    logic [WIDTH-1:0]     mul_b_o;
    logic                 mul_done_i;
    logic [2*WIDTH-1:0]   mul_product_i;
    logic [WIDTH-1:0]     mul_rounded_i;

    logic                 resp_valid_o;
    logic                 resp_ready_i;
    logic [2*WIDTH-1:0]   resp_product_o;
    logic [WIDTH-1:0]     resp_rounded_o;
    logic [TAG_W-1:0]     resp_tag_o;
    logic                 resp_err_o;

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, req_tag_i,
        input  mul_done_i, mul_product_i, mul_rounded_i,
        input  resp_ready_i,
        output req_ready_o, mul_start_o, mul_a_o, mul_b_o,
        output resp_valid_o, resp_product_o, resp_rounded_o, resp_tag_o, resp_err_o
    );

    modport master (
        output req_valid_i, req_a_i, req_b_i, req_tag_i,
        output mul_done_i, mul_product_i, mul_rounded_i,
        output resp_ready_i,
        input  req_ready_o, mul_start_o, mul_a_o, mul_b_o,
        input  resp_valid_o, resp_product_o, resp_rounded_o, resp_tag_o, resp_err_o
    );

endinterface

// File: rtl/mul_cycle_timer.sv
// Loadable down-counter shared by the BUSY timeout and the CAPTURE delay.
module mul_cycle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] value_o,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o   = cnt_q;
    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/response controller wrapped around the Booth radix-16 multiplier datapath.
// state   | meaning
// IDLE    | ready for a request
// START   | one-cycle start pulse, arm timeout
// BUSY    | waiting for done or timeout
// CAPTURE | waiting DONE_TO_PRODUCT cycles, then latch product
// RESP    | response held until accepted
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH           = WIDTH_DEF,
    parameter int TAG_W           = TAG_W_DEF,
    parameter int DONE_TO_PRODUCT = DONE_TO_PRODUCT_DEF,
    parameter int TIMEOUT         = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    mul_issue_ctrl_if.slave   bus,
    output logic              busy_o,
    output logic              spurious_done_o
);

    localparam logic [2:0] ST_IDLE    = IDLE;
    localparam logic [2:0] ST_START   = START;
    localparam logic [2:0] ST_BUSY    = BUSY;
    localparam logic [2:0] ST_CAPTURE = CAPTURE;
    localparam logic [2:0] ST_RESP    = RESP;

    localparam int               CNT_W    = timer_width(TIMEOUT + DONE_TO_PRODUCT);
    // Loaded in START so the timeout fires TIMEOUT cycles after the start pulse.
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT - 2);
    localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(DONE_TO_PRODUCT);

    logic [2:0]         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   rnd_q, rnd_d;
    logic               err_q, err_d;
    logic               spur_q, spur_d;

    logic               tmr_load, tmr_en, tmr_expired;
    logic [CNT_W-1:0]   tmr_load_val, tmr_value;

    mul_cycle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .value_o    (tmr_value),
        .expired_o  (tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        tag_d        = tag_q;
        prod_d       = prod_q;
        rnd_d        = rnd_q;
        err_d        = err_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;
        spur_d       = spur_q | (bus.mul_done_i && (state_q != ST_BUSY));

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    a_d     = bus.req_a_i;
                    b_d     = bus.req_b_i;
                    tag_d   = bus.req_tag_i;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tmr_load     = 1'b1;
                tmr_load_val = TO_LOAD;
                state_d      = ST_BUSY;
            end
            ST_BUSY: begin
                tmr_en = 1'b1;
                if (bus.mul_done_i) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = DLY_LOAD;
                    state_d      = ST_CAPTURE;
                end else if (tmr_expired) begin
                    prod_d  = '0;
                    rnd_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_CAPTURE: begin
                tmr_en = 1'b1;
                if (tmr_value == '0) begin
                    prod_d  = bus.mul_product_i;
                    rnd_d   = bus.mul_rounded_i;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready_i) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            prod_q  <= '0;
            rnd_q   <= '0;
            err_q   <= 1'b0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tag_q   <= tag_d;
            prod_q  <= prod_d;
            rnd_q   <= rnd_d;
            err_q   <= err_d;
            spur_q  <= spur_d;
        end
    end

    assign bus.req_ready_o    = (state_q == ST_IDLE);
    assign bus.mul_start_o    = (state_q == ST_START);
    assign bus.mul_a_o        = a_q;
    assign bus.mul_b_o        = b_q;
    assign bus.resp_valid_o   = (state_q == ST_RESP);
    assign bus.resp_product_o = prod_q;
    assign bus.resp_rounded_o = rnd_q;
    assign bus.resp_tag_o     = tag_q;
    assign bus.resp_err_o     = err_q;
    assign busy_o             = (state_q != ST_IDLE);
    assign spurious_done_o    = spur_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed scoreboard bench for mul_issue_ctrl with a behavioural datapath model.
module tb_mul_issue_ctrl;
    import mul_pkg::*;

    localparam int W  = WIDTH_DEF;
    localparam int TW = TAG_W_DEF;

    typedef struct packed {
        logic [2*W-1:0] prod;
        logic [W-1:0]   rnd;
        logic [TW-1:0]  tag;
        logic           err;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*W-1:0] mul64(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = a * b;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- main DUT (DONE_TO_PRODUCT = 1, TIMEOUT = 64) ----------------
    mul_issue_ctrl_if #(.WIDTH(W), .TAG_W(TW)) ifc ();
    logic busy, spur;

    mul_issue_ctrl #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (ifc.slave),
        .busy_o          (busy),
        .spurious_done_o (spur)
    );

    int   lat    = 9;
    bit   never  = 1'b0;
    int   mj     = 0;
    bit   mact   = 1'b0;
    logic m_done = 1'b0;
    logic tb_done = 1'b0;
    logic [2*W-1:0] m_prod = '0;

    assign ifc.mul_done_i    = m_done | tb_done;
    assign ifc.mul_product_i = m_prod;
    assign ifc.mul_rounded_i = m_prod[2*W-1:W];

    // Datapath model: done in cycle START+lat, correct product only in START+lat+2.
    always @(negedge clk) begin
        if (rst) begin
            mact   = 1'b0;
            mj     = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (ifc.mul_start_o) begin
                mact = 1'b1;
                mj   = 0;
            end else if (mact) begin
                mj++;
                if (mj == lat && !never) m_done = 1'b1;
                if (!never && mj > lat + 2) mact = 1'b0;
            end
        end
        m_prod = (mact && mj == lat + 2) ? mul64(ifc.mul_a_o, ifc.mul_b_o)
                                         : ~mul64(ifc.mul_a_o, ifc.mul_b_o);
    end

    int starts    = 0;
    int start_cyc = 0;
    always @(posedge clk) if (!rst && ifc.mul_start_o) starts++;
    always @(negedge clk) if (ifc.mul_start_o) start_cyc = cyc;

    resp_t sb[$];

    // ---------------- DONE_TO_PRODUCT sweep instances ----------------
    logic          sw_valid = 1'b0;
    logic [W-1:0]  sw_a = '0, sw_b = '0;
    logic [TW-1:0] sw_tag = '0;
    logic [2*W-1:0] sw_res [4];
    logic           sw_got [4];
    logic           sw_err [4];

    for (genvar g = 0; g < 4; g++) begin : g_sw
        mul_issue_ctrl_if #(.WIDTH(W), .TAG_W(TW)) sif ();
        logic sbusy, sspur;
        int   sj = 0;
        bit   sact = 1'b0;
        logic sd = 1'b0;
        logic [2*W-1:0] sp = '0;
        logic [2*W-1:0] res = '0;
        logic got = 1'b0;
        logic gerr = 1'b0;

        mul_issue_ctrl #(.WIDTH(W), .TAG_W(TW), .DONE_TO_PRODUCT(g)) u_dut (
            .clk             (clk),
            .rst             (rst),
            .bus             (sif.slave),
            .busy_o          (sbusy),
            .spurious_done_o (sspur)
        );

        assign sif.req_valid_i   = sw_valid;
        assign sif.req_a_i       = sw_a;
        assign sif.req_b_i       = sw_b;
        assign sif.req_tag_i     = sw_tag;
        assign sif.resp_ready_i  = 1'b1;
        assign sif.mul_done_i    = sd;
        assign sif.mul_product_i = sp;
        assign sif.mul_rounded_i = sp[2*W-1:W];

        always @(negedge clk) begin
            if (rst) begin
                sact = 1'b0;
                sj   = 0;
                sd   = 1'b0;
                got  = 1'b0;
            end else begin
                sd = 1'b0;
                if (sif.mul_start_o) begin
                    sact = 1'b1;
                    sj   = 0;
                end else if (sact) begin
                    sj++;
                    if (sj == 5) sd = 1'b1;
                    if (sj > 6 + g) sact = 1'b0;
                end
                if (sif.resp_valid_o && !got) begin
                    got  = 1'b1;
                    res  = sif.resp_product_o;
                    gerr = sif.resp_err_o;
                end
            end
            sp = (sact && sj == 6 + g) ? mul64(sif.mul_a_o, sif.mul_b_o)
                                       : ~mul64(sif.mul_a_o, sif.mul_b_o);
        end

        assign sw_res[g] = res;
        assign sw_got[g] = got;
        assign sw_err[g] = gerr;
    end

    // ---------------- tasks ----------------
    task automatic send_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag,
                            input bit push, input bit err);
        resp_t e;
        int k;
        ifc.req_valid_i = 1'b1;
        ifc.req_a_i     = a;
        ifc.req_b_i     = b;
        ifc.req_tag_i   = tag;
        e.prod = err ? '0 : mul64(a, b);
        e.rnd  = e.prod[2*W-1:W];
        e.tag  = tag;
        e.err  = err;
        if (push) sb.push_back(e);
        k = 0;
        while (!ifc.req_ready_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("req_accept_bound", 64'(ifc.req_ready_o), 64'd1);
        @(posedge clk);
        @(negedge clk);
        ifc.req_valid_i = 1'b0;
        chk("ready_low_after_accept", 64'(ifc.req_ready_o), 64'd0);
    endtask

    task automatic wait_resp(input int max, output int cyc_at);
        int    k;
        int    rdy_bad;
        resp_t e;
        k = 0;
        rdy_bad = 0;
        while (!ifc.resp_valid_o && k < max) begin
            if (ifc.req_ready_o) rdy_bad++;
            @(negedge clk);
            k++;
        end
        cyc_at = cyc;
        chk("resp_valid_bound", 64'(ifc.resp_valid_o), 64'd1);
        chk("ready_low_while_busy", 64'(rdy_bad), 64'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("resp_product", ifc.resp_product_o, e.prod);
            chk("resp_rounded", 64'(ifc.resp_rounded_o), 64'(e.rnd));
            chk("resp_tag", 64'(ifc.resp_tag_o), 64'(e.tag));
            chk("resp_err", 64'(ifc.resp_err_o), 64'(e.err));
        end else begin
            chk("scoreboard_nonempty", 64'(sb.size()), 64'd1);
        end
    endtask

    task automatic handshake();
        ifc.resp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.resp_ready_i = 1'b0;
        chk("valid_after_hs", 64'(ifc.resp_valid_o), 64'd0);
        chk("err_after_hs", 64'(ifc.resp_err_o), 64'd0);
        chk("ready_after_hs", 64'(ifc.req_ready_o), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 64'({ifc.req_ready_o, busy, ifc.resp_valid_o, ifc.mul_start_o,
                                ifc.resp_err_o, spur}), 64'b100000);
        chk({tag, "_ops"}, {ifc.mul_a_o, ifc.mul_b_o}, '0);
        chk({tag, "_resp"}, ifc.resp_product_o | 64'(ifc.resp_rounded_o) | 64'(ifc.resp_tag_o), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int    c;
        int    s0;
        int    bad;
        int    k;
        logic [2*W-1:0] snap_p;
        logic [TW-1:0]  snap_t;
        logic [2*W-1:0] sw_exp;

        ifc.req_valid_i  = 1'b0;
        ifc.req_a_i      = '0;
        ifc.req_b_i      = '0;
        ifc.req_tag_i    = '0;
        ifc.resp_ready_i = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");

        // 1. basic multiply
        lat = 9;
        s0  = starts;
        send_req(32'd7, -32'sd3, 4'd5, 1'b1, 1'b0);
        wait_resp(100, c);
        chk("basic_product_const", ifc.resp_product_o, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("basic_one_start", 64'(starts - s0), 64'd1);
        handshake();

        // 2. backpressure, with a request waiting
        lat = 4;
        send_req(-32'sd5, 32'd11, 4'd3, 1'b1, 1'b0);
        wait_resp(100, c);
        snap_p = ifc.resp_product_o;
        snap_t = ifc.resp_tag_o;
        ifc.req_valid_i = 1'b1;
        ifc.req_a_i     = 32'd2;
        ifc.req_b_i     = 32'd3;
        ifc.req_tag_i   = 4'd9;
        sb.push_back('{prod: 64'd6, rnd: 32'd0, tag: 4'd9, err: 1'b0});
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifc.resp_valid_o !== 1'b1 || ifc.resp_product_o !== snap_p ||
                ifc.resp_tag_o !== snap_t || ifc.resp_err_o !== 1'b0 || ifc.req_ready_o !== 1'b0)
                bad++;
        end
        chk("backpressure_stable", 64'(bad), 64'd0);
        handshake();
        chk("no_accept_in_hs_cycle", 64'(busy), 64'd0);
        @(posedge clk);
        @(negedge clk);
        ifc.req_valid_i = 1'b0;
        chk("accept_after_hs", 64'(busy), 64'd1);
        wait_resp(100, c);
        handshake();

        // 3a. timeout
        never = 1'b1;
        send_req(32'd4, 32'd5, 4'd7, 1'b1, 1'b1);
        wait_resp(200, c);
        chk("timeout_latency", 64'(c - start_cyc), 64'd64);
        handshake();
        never = 1'b0;

        // 3b. done in the same cycle as the timeout
        lat = 63;
        send_req(32'd6, 32'd7, 4'd8, 1'b1, 1'b0);
        wait_resp(200, c);
        handshake();

        // 4. DONE_TO_PRODUCT sweep
        sw_exp   = mul64(32'd123, 32'd100);
        sw_a     = 32'd123;
        sw_b     = 32'd100;
        sw_tag   = 4'd4;
        sw_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sw_valid = 1'b0;
        k = 0;
        while (!(sw_got[0] && sw_got[1] && sw_got[2] && sw_got[3]) && k < 60) begin
            @(negedge clk);
            k++;
        end
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("sweep_got_d%0d", g), 64'(sw_got[g]), 64'd1);
            chk($sformatf("sweep_prod_d%0d", g), sw_res[g], sw_exp);
            chk($sformatf("sweep_err_d%0d", g), 64'(sw_err[g]), 64'd0);
        end

        // 5. reset mid-operation
        never = 1'b1;
        send_req(32'd9, 32'd9, 4'd1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("busy_before_reset", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("in_reset");
        rst = 1'b0;
        never = 1'b0;
        @(negedge clk);
        chk_reset_outputs("after_reset");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifc.resp_valid_o !== 1'b0) bad++;
        end
        chk("no_resp_after_abort", 64'(bad), 64'd0);
        lat = 3;
        send_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 1'b1, 1'b0);
        wait_resp(100, c);
        chk("neg1_squared", ifc.resp_product_o, 64'd1);
        handshake();

        // 6. spurious done
        chk("spur_clear", 64'(spur), 64'd0);
        tb_done = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
        chk("spur_set", 64'(spur), 64'd1);
        chk("spur_state_idle", 64'(busy), 64'd0);
        lat = 6;
        send_req(32'd100, -32'sd7, 4'd11, 1'b1, 1'b0);
        wait_resp(100, c);
        handshake();
        chk("spur_sticky", 64'(spur), 64'd1);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
